// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/flag controller for an async FIFO: binary+Gray write pointer, full,
// almost_full, occupancy estimate. Optional sticky overflow flag via WPTR_OVERFLOW_FLAG_EN.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int AFULL_THRESH = 4,
  localparam int PW          = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [PW-1:0]         wq2_rptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [PW-1:0]         wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [PW-1:0]         wr_level,
  output logic                  overflow
);

  localparam int            DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AFULL_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic          full_q, full_d;
  logic          almost_full_q, almost_full_d;
  logic [PW-1:0] wr_level_q, wr_level_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic          winc;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_g2b
      assign rbin[gi] = ^(wq2_rptr >> gi);
    end
  endgenerate

  // Full when the write Gray pointer equals the read pointer with its top two bits inverted.
  assign full_cmp = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
  assign winc     = wr_en & ~full_q;

  always_comb begin
    wbin_d        = wbin_q + PW'(winc);
    wptr_d        = wbin_d ^ (wbin_d >> 1);
    full_d        = (wptr_d == full_cmp);
    wr_level_d    = wbin_d - rbin;
    almost_full_d = (wr_level_d >= AF_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q        <= '0;
      wptr_q        <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_level_q    <= '0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wr_level_q    <= wr_level_d;
    end
  end

`ifdef WPTR_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  // Sticky until reset: any write attempt while full is a producer protocol error.
  always_comb begin
    overflow_d = overflow_q | (wr_en & full_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wptr        = wptr_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_level    = wr_level_q;

endmodule
